// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle instruction sequencer. Each instruction is walked through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The sequencer handshakes with
//   instruction memory (fetchReq/insValid) and data memory (memRead|memWrite /
//   dmemReady). It drives the IR/PC load strobes and the ALU, register file
//   and memory enables.
//
//   Outputs are decoded from the current state and the opcode that was latched
//   at the fetch handshake. irWrite/pcWrite also depend on insValid, because
//   they mark the handshake cycle itself. All outputs are forced low while
//   reset is high.
//
//   Optional feature macro: ILLEGAL_TRAP_EN
//     defined   : an unknown opcode pulses trap in DECODE for one cycle. The
//                 sequencer then parks in HALT with every output low. Only
//                 reset leaves HALT.
//     undefined : an unknown opcode is a two-cycle no-op (DECODE -> FETCH), and
//                 trap is tied low.
//
// Parameters
//   INS_W  instruction width
//   OP_HI  MSB index of the opcode field in ins
//   OP_W   opcode field width (>= ALU_W)
//   ALU_W  ALU function width; taken from the top ALU_W bits of the opcode
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ins, insValid       instruction word and its valid flag from imem
//   dmemReady           data memory access complete (only looked at in MEM)
//   fetchReq            instruction request, held until insValid
//   irWrite, pcWrite    one-cycle strobes on the fetch handshake
//   aluOp, ALUSrc       ALU function / immediate operand select
//   regDst, regWriteEnable, memToReg   register file writeback controls
//   memRead, memWrite   data memory request, held until dmemReady
//   branchEnable, jump, link           control-transfer qualifiers
//   trap                illegal opcode indication
module multicycle_control #(
  parameter int unsigned INS_W = 32,
  parameter int unsigned OP_HI = 31,
  parameter int unsigned OP_W  = 6,
  parameter int unsigned ALU_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [INS_W-1:0] ins,
  input  logic             insValid,
  input  logic             dmemReady,
  output logic             fetchReq,
  output logic             irWrite,
  output logic             pcWrite,
  output logic [ALU_W-1:0] aluOp,
  output logic             ALUSrc,
  output logic             regDst,
  output logic             regWriteEnable,
  output logic             memToReg,
  output logic             memRead,
  output logic             memWrite,
  output logic             branchEnable,
  output logic             jump,
  output logic             link,
  output logic             trap
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  // Opcode encodings, zero-extended if the opcode field is wider than 6 bits.
  localparam logic [OP_W-1:0] OpAnd  = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] OpNor  = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OpNot  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OpRolv = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OpRorv = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OpNori = OP_W'(6'b001110);
  localparam logic [OP_W-1:0] OpLw   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OpSw   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OpJr   = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OpJal  = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OpBleu = OP_W'(6'b010000);

  state_e          r_state;
  state_e          w_next_state;
  logic [OP_W-1:0] r_opcode;

  logic [OP_W-1:0] w_opcode_in;
  logic            w_fetch_hs;

  // Decoded latched opcode
  logic w_op_alu;
  logic w_op_nori;
  logic w_op_lw;
  logic w_op_sw;
  logic w_op_jr;
  logic w_op_jal;
  logic w_op_bleu;
  logic w_known;

  // Ungated output values
  logic w_fetch_req;
  logic w_ir_write;
  logic w_pc_write;
  logic w_alu_en;
  logic w_alu_src;
  logic w_reg_dst;
  logic w_reg_we;
  logic w_mem_to_reg;
  logic w_mem_read;
  logic w_mem_write;
  logic w_branch;
  logic w_jump;
  logic w_link;
  logic w_trap;

  // Only the opcode field of ins is used here; the rest goes to the datapath.
  logic w_unused_ins;
  assign w_unused_ins = ^ins;

  assign w_opcode_in = ins[OP_HI -: OP_W];
  assign w_fetch_hs  = (r_state == StFetch) && insValid;

  // ---------------------------------------------------------------------------
  // Opcode classification
  // ---------------------------------------------------------------------------
  assign w_op_nori = (r_opcode == OpNori);
  assign w_op_lw   = (r_opcode == OpLw);
  assign w_op_sw   = (r_opcode == OpSw);
  assign w_op_jr   = (r_opcode == OpJr);
  assign w_op_jal  = (r_opcode == OpJal);
  assign w_op_bleu = (r_opcode == OpBleu);
  assign w_op_alu  = (r_opcode == OpAnd)  || (r_opcode == OpNor)  ||
                     (r_opcode == OpNot)  || (r_opcode == OpRolv) ||
                     (r_opcode == OpRorv) || w_op_nori;
  assign w_known   = w_op_alu || w_op_lw || w_op_sw || w_op_jr || w_op_jal || w_op_bleu;

  // ---------------------------------------------------------------------------
  // State and opcode registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StFetch;
      r_opcode <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_fetch_hs) begin
        r_opcode <= w_opcode_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_fetch_req  = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_alu_en     = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_we     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_link       = 1'b0;
    w_trap       = 1'b0;

    unique case (r_state)
      StFetch: begin
        w_fetch_req = 1'b1;
        if (insValid) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = StDecode;
        end
      end

      StDecode: begin
        if (w_known) begin
          w_next_state = StExec;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          w_trap       = 1'b1;
          w_next_state = StHalt;
`else
          w_next_state = StFetch;
`endif
        end
      end

      StExec: begin
        w_alu_en  = 1'b1;
        w_alu_src = w_op_nori;
        if (w_op_bleu) begin
          w_branch     = 1'b1;
          w_next_state = StFetch;
        end else if (w_op_jr) begin
          w_jump       = 1'b1;
          w_next_state = StFetch;
        end else if (w_op_jal) begin
          // Return address goes to $ra in the same cycle as the redirect.
          w_jump       = 1'b1;
          w_link       = 1'b1;
          w_reg_we     = 1'b1;
          w_next_state = StFetch;
        end else if (w_op_lw || w_op_sw) begin
          w_next_state = StMem;
        end else begin
          w_next_state = StWb;
        end
      end

      StMem: begin
        // Address stays on the ALU while the request is outstanding.
        w_alu_en    = 1'b1;
        w_mem_read  = w_op_lw;
        w_mem_write = w_op_sw;
        if (dmemReady) begin
          w_next_state = w_op_lw ? StWb : StFetch;
        end
      end

      StWb: begin
        w_reg_we     = 1'b1;
        w_reg_dst    = !w_op_lw;
        w_mem_to_reg = w_op_lw;
        w_next_state = StFetch;
      end

      StHalt: begin
`ifdef ILLEGAL_TRAP_EN
        w_next_state = StHalt;
`else
        w_next_state = StFetch;
`endif
      end

      default: begin
        w_next_state = StFetch;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs, forced low asynchronously while reset is high
  // ---------------------------------------------------------------------------
  assign fetchReq       = w_fetch_req  && !reset;
  assign irWrite        = w_ir_write   && !reset;
  assign pcWrite        = w_pc_write   && !reset;
  assign aluOp          = (w_alu_en && !reset) ? r_opcode[OP_W-1 -: ALU_W] : '0;
  assign ALUSrc         = w_alu_src    && !reset;
  assign regDst         = w_reg_dst    && !reset;
  assign regWriteEnable = w_reg_we     && !reset;
  assign memToReg       = w_mem_to_reg && !reset;
  assign memRead        = w_mem_read   && !reset;
  assign memWrite       = w_mem_write  && !reset;
  assign branchEnable   = w_branch     && !reset;
  assign jump           = w_jump       && !reset;
  assign link           = w_link       && !reset;
  assign trap           = w_trap       && !reset;

endmodule
